// File: rtl/status_line_scheduler_if.sv
// Text buffer write port: one ASCII character per valid/ready handshake.
interface status_line_scheduler_if #(
    parameter int ADDR_W = 6
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/status_line_scheduler.sv
// Watches puzzle module states and rewrites a changed module's status line,
// one looked-up character per write, round-robin across pending modules.
module status_line_scheduler #(
    parameter int NUM_MODULES = 4,
    parameter int STATE_W     = 3,
    parameter int LINE_CHARS  = 16,
    parameter int ADDR_W      = 6,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_MODULES*STATE_W-1:0] mod_state,
    input  logic                           force_refresh,
    output logic [2:0]                     str_module,
    output logic [STATE_W-1:0]             str_state,
    output logic [IDX_W-1:0]               str_idx,
    input  logic [7:0]                     char_in,
    status_line_scheduler_if.master        wr,
    output logic                           busy
);

    localparam int MOD_W = $clog2(NUM_MODULES);
    localparam logic [ADDR_W-1:0] LINE_A   = ADDR_W'(LINE_CHARS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_CHARS - 1);
    localparam logic [MOD_W-1:0]  LAST_MOD = MOD_W'(NUM_MODULES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [MOD_W-1:0]     grant_q, grant_d;
    logic [MOD_W-1:0]     rr_q, rr_d;
    logic [MOD_W-1:0]     pick;
    logic [NUM_MODULES-1:0] pending_q, pending_d;
    logic [STATE_W-1:0]   last_q [NUM_MODULES];
    logic [STATE_W-1:0]   last_d [NUM_MODULES];
    logic [2:0]           str_module_q, str_module_d;
    logic [STATE_W-1:0]   str_state_q, str_state_d;
    logic [IDX_W-1:0]     str_idx_q, str_idx_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;

    // First pending module at or after rr_q, wrapping modulo NUM_MODULES.
    always_comb begin
        logic [MOD_W:0] cand;
        logic           found;
        pick  = rr_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_MODULES; i++) begin
            cand = {1'b0, rr_q} + (MOD_W + 1)'(i);
            if (cand >= (MOD_W + 1)'(NUM_MODULES)) begin
                cand = cand - (MOD_W + 1)'(NUM_MODULES);
            end
            if (!found && pending_q[cand[MOD_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[MOD_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        pending_d    = pending_q;
        last_d       = last_q;
        str_module_d = str_module_q;
        str_state_d  = str_state_q;
        str_idx_d    = str_idx_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        for (int unsigned k = 0; k < NUM_MODULES; k++) begin
            if (force_refresh || (mod_state[k*STATE_W +: STATE_W] != last_q[k])) begin
                pending_d[k] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    grant_d = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Granted module is compared against its freshly latched state,
                // so only force_refresh can keep its pending bit set here.
                for (int unsigned k = 0; k < NUM_MODULES; k++) begin
                    if (grant_q == MOD_W'(k)) begin
                        last_d[k]    = mod_state[k*STATE_W +: STATE_W];
                        str_state_d  = mod_state[k*STATE_W +: STATE_W];
                        pending_d[k] = force_refresh;
                    end
                end
                str_module_d = 3'(grant_q);
                str_idx_d    = '0;
                rr_d         = (grant_q == LAST_MOD) ? '0 : grant_q + MOD_W'(1);
                state_d      = STREAM;
            end
            STREAM: begin
                if (!wr_valid_q || wr.wr_ready) begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = char_in;
                    wr_addr_d  = ADDR_W'(str_module_q) * LINE_A + ADDR_W'(str_idx_q);
                    if (str_idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        str_idx_d = str_idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (wr.wr_ready) begin
                    wr_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_q         <= '0;
            pending_q    <= '1;
            last_q       <= '{default: '0};
            str_module_q <= '0;
            str_state_q  <= '0;
            str_idx_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_q         <= rr_d;
            pending_q    <= pending_d;
            last_q       <= last_d;
            str_module_q <= str_module_d;
            str_state_q  <= str_state_d;
            str_idx_q    <= str_idx_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign str_module  = str_module_q;
    assign str_state   = str_state_q;
    assign str_idx     = str_idx_q;
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_status_line_scheduler.sv
// Directed bench for status_line_scheduler: expected lines are hand-derived
// from module index, latched state and character index.
module tb_status_line_scheduler;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int LC = 16;
    localparam int AW = 6;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*SW-1:0] mod_state;
    logic            force_refresh;
    logic [2:0]      str_module;
    logic [SW-1:0]   str_state;
    logic [IW-1:0]   str_idx;
    logic [7:0]      char_in;
    logic            busy;

    status_line_scheduler_if #(.ADDR_W(AW)) wr_if ();

    status_line_scheduler #(
        .NUM_MODULES(N),
        .STATE_W    (SW),
        .LINE_CHARS (LC),
        .ADDR_W     (AW),
        .IDX_W      (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mod_state    (mod_state),
        .force_refresh(force_refresh),
        .str_module   (str_module),
        .str_state    (str_state),
        .str_idx      (str_idx),
        .char_in      (char_in),
        .wr           (wr_if),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the string lookup: every (module, state, index) maps to a distinct byte.
    assign char_in = {str_module[0], str_state, str_idx};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] q_addr [$];
    logic [7:0]    q_data [$];
    logic [SW-1:0] q_st   [$];
    int            n_busy  = 0;
    int            n_valid = 0;

    initial begin
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        logic [7:0]    prev_data;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (busy) n_busy++;
                if (wr_if.wr_valid) n_valid++;
                if (prev_stall) begin
                    check("hold_valid", 32'(wr_if.wr_valid), 32'd1);
                    check("hold_addr", 32'(wr_if.wr_addr), 32'(prev_addr));
                    check("hold_data", 32'(wr_if.wr_data), 32'(prev_data));
                end
                prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
                prev_addr  = wr_if.wr_addr;
                prev_data  = wr_if.wr_data;
                if (wr_if.wr_valid && wr_if.wr_ready) begin
                    q_addr.push_back(wr_if.wr_addr);
                    q_data.push_back(wr_if.wr_data);
                    q_st.push_back(str_state);
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int quiet = 0;
        int t = 0;
        while (quiet < 4 && t < budget) begin
            tick();
            t++;
            if (busy) quiet = 0;
            else quiet++;
        end
        check({tag, "_settle"}, 32'(quiet >= 4), 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int base, input int n, input int budget);
        int t = 0;
        while ((q_addr.size() - base) != n && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_reach"}, 32'(q_addr.size() - base), 32'(n));
    endtask

    task automatic check_line(input string tag, input int pos, input int m, input int s);
        for (int i = 0; i < LC; i++) begin
            check({tag, "_addr"}, 32'(q_addr[pos+i]), 32'(m * LC + i));
            check({tag, "_data"}, 32'(q_data[pos+i]), 32'((m % 2) * 128 + s * 16 + i));
            check({tag, "_state"}, 32'(q_st[pos+i]), 32'(s));
        end
    endtask

    initial begin
        int base;
        int vb;
        int bb;

        reset_n          = 1'b0;
        mod_state        = '0;
        force_refresh    = 1'b0;
        wr_if.wr_ready   = 1'b1;
        repeat (3) tick();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(wr_if.wr_valid), 32'd0);
        check("rst_addr", 32'(wr_if.wr_addr), 32'd0);
        check("rst_data", 32'(wr_if.wr_data), 32'd0);
        check("rst_module", 32'(str_module), 32'd0);
        check("rst_state", 32'(str_state), 32'd0);
        check("rst_idx", 32'(str_idx), 32'd0);

        // All lines drawn after reset, in order 0..3.
        base = q_addr.size(); vb = n_valid; bb = n_busy;
        reset_n = 1'b1;
        wait_idle("boot", 300);
        check("boot_count", 32'(q_addr.size() - base), 32'd64);
        for (int m = 0; m < N; m++) check_line("boot", base + m * LC, m, 0);
        check("boot_busy_cycles", 32'(n_busy - bb), 32'd72);
        check("boot_valid_cycles", 32'(n_valid - vb), 32'd64);

        // Single module change.
        base = q_addr.size(); vb = n_valid; bb = n_busy;
        mod_state[8:6] = 3'd3;
        wait_idle("m2", 100);
        check("m2_count", 32'(q_addr.size() - base), 32'd16);
        check_line("m2", base, 2, 3);
        check("m2_busy_cycles", 32'(n_busy - bb), 32'd18);
        check("m2_valid_cycles", 32'(n_valid - vb), 32'd16);

        // Module 1 alone moves rr_ptr to 2.
        base = q_addr.size();
        mod_state[5:3] = 3'd5;
        wait_idle("m1", 100);
        check("m1_count", 32'(q_addr.size() - base), 32'd16);
        check_line("m1", base, 1, 5);

        // Modules 1 and 3 together with rr_ptr=2: module 3 first.
        base = q_addr.size();
        mod_state[5:3]  = 3'd2;
        mod_state[11:9] = 3'd6;
        wait_idle("rr", 150);
        check("rr_count", 32'(q_addr.size() - base), 32'd32);
        check_line("rr_first", base, 3, 6);
        check_line("rr_second", base + LC, 1, 2);

        // Back-pressure for 5 cycles while character 7 is presented.
        base = q_addr.size(); vb = n_valid; bb = n_busy;
        mod_state[2:0] = 3'd4;
        wait_acc("stall", base, 7, 50);
        wr_if.wr_ready = 1'b0;
        repeat (5) tick();
        wr_if.wr_ready = 1'b1;
        wait_idle("stall", 100);
        check("stall_count", 32'(q_addr.size() - base), 32'd16);
        check_line("stall", base, 0, 4);
        check("stall_valid_cycles", 32'(n_valid - vb), 32'd21);
        check("stall_busy_cycles", 32'(n_busy - bb), 32'd23);

        // State change during own stream: snapshot kept, line redrawn afterwards.
        base = q_addr.size();
        mod_state[2:0] = 3'd1;
        wait_acc("snap", base, 3, 50);
        mod_state[2:0] = 3'd2;
        wait_idle("snap", 150);
        check("snap_count", 32'(q_addr.size() - base), 32'd32);
        check_line("snap_first", base, 0, 1);
        check_line("snap_second", base + LC, 0, 2);

        // Reset in the middle of module 3's line.
        base = q_addr.size();
        mod_state[11:9] = 3'd7;
        wait_acc("mrst", base, 9, 50);
        reset_n = 1'b0;
        tick();
        check("mrst_valid", 32'(wr_if.wr_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_idx", 32'(str_idx), 32'd0);
        reset_n = 1'b1;
        base = q_addr.size();
        wait_idle("mrst", 300);
        check("mrst_count", 32'(q_addr.size() - base), 32'd64);
        check_line("mrst_l0", base, 0, 2);
        check_line("mrst_l1", base + LC, 1, 2);
        check_line("mrst_l2", base + 2 * LC, 2, 3);
        check_line("mrst_l3", base + 3 * LC, 3, 7);

        // force_refresh redraws every line.
        base = q_addr.size();
        force_refresh = 1'b1;
        tick();
        force_refresh = 1'b0;
        wait_idle("force", 300);
        check("force_count", 32'(q_addr.size() - base), 32'd64);
        check_line("force_l0", base, 0, 2);
        check_line("force_l1", base + LC, 1, 2);
        check_line("force_l2", base + 2 * LC, 2, 3);
        check_line("force_l3", base + 3 * LC, 3, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_line_scheduler.md
Name: status_line_scheduler

Overview:
- Sequences the module-state-to-string lookup for the bomb status display.
- Watches the state code of every puzzle module and keeps one pending flag per module.
- Picks one pending module round-robin, then drives the combinational state-to-string lookup one character at a time.
- Streams the resulting LINE_CHARS ASCII characters into that module's line of the display text buffer, using a valid/ready write port.

Parameters:
- NUM_MODULES, 4, number of puzzle modules (lines); range 2..8
- STATE_W, 3, width of each module state code
- LINE_CHARS, 16, characters per display line; range 2..32
- ADDR_W, 6, text buffer address width; must satisfy 2^ADDR_W >= NUM_MODULES*LINE_CHARS
- IDX_W, 4, character index width; must satisfy 2^IDX_W >= LINE_CHARS

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- mod_state  in  NUM_MODULES*STATE_W  packed module states; module k is at bits [k*STATE_W +: STATE_W]
- force_refresh  in  1  single-cycle pulse; marks every module pending
- str_module  out  3  module index presented to the lookup (zero-extended)
- str_state  out  STATE_W  latched state presented to the lookup
- str_idx  out  IDX_W  character index presented to the lookup
- char_in  in  8  ASCII from the lookup, combinational from str_*
- wr_valid  out  1  text buffer write request
- wr_addr  out  ADDR_W  str_module*LINE_CHARS + character index
- wr_data  out  8  character to write
- wr_ready  in  1  text buffer accepts the write when wr_valid && wr_ready
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Outputs: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, str_module=0, str_state=0, str_idx=0, busy=0.
  - Internal: last_state[k]=0 for all k, rr_ptr=0, pending=all ones, so every line is drawn after reset.
  - Reset mid-stream aborts immediately; the partial line is rewritten later, because pending is all ones.
- Change detection, every cycle:
  - pending[k] is set when mod_state[k] != last_state[k].
  - force_refresh sets all pending bits.
- Grant:
  - In IDLE with any pending bit set, pick the first pending k, searching rr_ptr, rr_ptr+1, … mod NUM_MODULES.
  - Next cycle, enter LOAD.
- LOAD (1 cycle):
  - str_module<=k, str_state<=mod_state[k], last_state[k]<=mod_state[k], str_idx<=0, rr_ptr<=(k+1) mod NUM_MODULES.
  - Clear pending[k] in this cycle. A set condition in the same cycle wins: force_refresh, or a change relative to the newly latched value in later cycles.
  - Go to STREAM.
- STREAM, issue condition is (!wr_valid || wr_ready):
  - wr_valid<=1, wr_data<=char_in, wr_addr<=str_module*LINE_CHARS+str_idx.
  - If str_idx==LINE_CHARS-1, go to DRAIN; else str_idx<=str_idx+1.
  - If the issue condition is false, hold all outputs stable.
- DRAIN:
  - Hold until wr_ready.
  - On wr_ready: wr_valid<=0, go to IDLE.
- Handshake rules:
  - wr_addr and wr_data never change while wr_valid=1 and wr_ready=0.
  - With wr_ready tied high, exactly one write per cycle: LINE_CHARS consecutive cycles of wr_valid.
  - First wr_valid rises 2 cycles after the grant edge.
- Snapshot rule: str_state is frozen for the whole line.
  - A module state change during its own stream re-sets its pending bit.
  - That module is serviced again after the round-robin turns of the other modules.
- Timing at wr_ready=1:
  - IDLE→IDLE turnaround between lines is LINE_CHARS+3 cycles (grant, LOAD, LINE_CHARS issues, DRAIN).
  - One idle cycle occurs between lines.

Test Plan:
- Reset released, mod_state=0, wr_ready=1 -> 4 lines written in order 0,1,2,3; addresses 0..63 each written once; busy falls after the 4th line.
- Idle system, module 2 state 0→3 -> one line written, wr_addr 32..47; str_state=3 during the whole stream; lookup char_in returned as wr_data unchanged.
- Modules 1 and 3 change in the same cycle with rr_ptr=2 -> module 3 line first (48..63), then module 1 (16..31); rr_ptr ends at 2.
- wr_ready low for 5 cycles at character 7 of a line -> wr_valid held high; wr_addr/wr_data unchanged; no character skipped or duplicated; 16 accepted writes in total.
- Module 0 changes 1→2 while its own line is streaming -> line finishes with state 1 text; pending[0] re-set; second pass writes state 2 text.
- reset_n pulled low at character 9 of a line, then released -> wr_valid=0 next cycle; all 4 lines rewritten from address 0.
